// File: rtl/spi_xfer_ctrl.sv
// rtl/spi_xfer_ctrl.sv - SPI mode 0 master moving words from a TX FIFO to an RX FIFO.
// Optional macro SPI_LSB_FIRST_EN selects LSB-first bit order; default build is MSB first.
module spi_xfer_ctrl #(
   parameter int WIDTH = 8,
   parameter int DIV   = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             tx_empty,
   input  logic [WIDTH-1:0] tx_dout,
   output logic             tx_rd,
   input  logic             rx_full,
   output logic [WIDTH-1:0] rx_din,
   output logic             rx_wr,
   output logic             sck,
   output logic             mosi,
   input  logic             miso,
   output logic             ss_n,
   output logic             busy
);

   localparam int DW = $clog2(DIV + 1);
   localparam int BW = $clog2(WIDTH + 1);
   localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, STORE} state_t;

   state_t           state, state_nxt;
   logic [DW-1:0]    div_cnt;
   logic [BW-1:0]    bit_cnt;
   logic [WIDTH-1:0] tx_sr;
   logic [WIDTH-1:0] rx_sr;
   logic             sck_q;
   logic             ss_q;
   logic             ready;
   logic             tick;
   logic             last_edge;
   logic             start_ok;

`ifdef SPI_LSB_FIRST_EN
   function automatic logic [WIDTH-1:0] tx_shift(input logic [WIDTH-1:0] v);
      return {1'b0, v[WIDTH-1:1]};
   endfunction
   function automatic logic [WIDTH-1:0] rx_shift(input logic [WIDTH-1:0] v, input logic b);
      return {b, v[WIDTH-1:1]};
   endfunction
   assign mosi = tx_sr[0];
`else
   function automatic logic [WIDTH-1:0] tx_shift(input logic [WIDTH-1:0] v);
      return {v[WIDTH-2:0], 1'b0};
   endfunction
   function automatic logic [WIDTH-1:0] rx_shift(input logic [WIDTH-1:0] v, input logic b);
      return {v[WIDTH-2:0], b};
   endfunction
   assign mosi = tx_sr[WIDTH-1];
`endif

   assign sck    = sck_q;
   assign ss_n   = ss_q;
   assign rx_din = rx_sr;

   // ready holds off the first start until one clock edge after reset release
   assign start_ok  = ready && en && !tx_empty && !rx_full;
   assign tick      = (state == SHIFT) && (div_cnt == DIV_LAST);
   assign last_edge = tick && sck_q && (bit_cnt == BIT_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      tx_rd     = 1'b0;
      rx_wr     = 1'b0;
      busy      = (state != IDLE);
      case (state)
         IDLE: begin
            if (start_ok) state_nxt = LOAD;
         end
         LOAD: begin
            tx_rd     = 1'b1;
            state_nxt = SHIFT;
         end
         SHIFT: begin
            if (last_edge) state_nxt = STORE;
         end
         STORE: begin
            rx_wr     = 1'b1;
            state_nxt = start_ok ? LOAD : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt <= '0;
         bit_cnt <= '0;
         tx_sr   <= '0;
         rx_sr   <= '0;
         sck_q   <= 1'b0;
         ss_q    <= 1'b1;
         ready   <= 1'b0;
      end else begin
         ready <= 1'b1;
         // The word is captured on the edge entering LOAD so mosi is valid throughout LOAD
         if (state_nxt == LOAD) begin
            tx_sr <= tx_dout;
            rx_sr <= '0;
            ss_q  <= 1'b0;
         end else if (state_nxt == IDLE) begin
            ss_q <= 1'b1;
         end
         case (state)
            LOAD: begin
               div_cnt <= '0;
               bit_cnt <= '0;
               sck_q   <= 1'b0;
            end
            SHIFT: begin
               if (tick) begin
                  div_cnt <= '0;
                  sck_q   <= ~sck_q;
                  if (!sck_q) begin
                     rx_sr <= rx_shift(rx_sr, miso);
                  end else begin
                     tx_sr   <= tx_shift(tx_sr);
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end else begin
                  div_cnt <= div_cnt + 1'b1;
               end
            end
            default: begin
               div_cnt <= '0;
               sck_q   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// tb/tb_spi_xfer_ctrl.sv - Scoreboard bench for spi_xfer_ctrl with loopback reference model.
module tb_spi_xfer_ctrl;

   localparam int WIDTH     = 8;
   localparam int DIV       = 2;
   localparam int SHIFT_CYC = 2 * WIDTH * DIV;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             en;
   logic             tx_empty;
   logic [WIDTH-1:0] tx_dout;
   logic             tx_rd;
   logic             rx_full;
   logic [WIDTH-1:0] rx_din;
   logic             rx_wr;
   logic             sck;
   logic             mosi;
   logic             miso;
   logic             ss_n;
   logic             busy;
   logic             loop;
   logic             miso_force;

   spi_xfer_ctrl #(.WIDTH(WIDTH), .DIV(DIV)) dut (
      .clk(clk), .rst_n(rst_n), .en(en),
      .tx_empty(tx_empty), .tx_dout(tx_dout), .tx_rd(tx_rd),
      .rx_full(rx_full), .rx_din(rx_din), .rx_wr(rx_wr),
      .sck(sck), .mosi(mosi), .miso(miso), .ss_n(ss_n), .busy(busy)
   );

   assign miso = loop ? mosi : miso_force;

   always #5 clk = ~clk;

   int               checks = 0;
   int               errors = 0;
   logic [WIDTH-1:0] tx_q[$];
   logic [WIDTH-1:0] exp_q[$];
   int               cyc = 0;
   int               load_cyc = 0;
   int               rises = 0;
   int               rx_cnt = 0;
   int               rd_cnt = 0;
   int               busy_cyc = 0;
   logic             prev_sck = 1'b0;
   logic [WIDTH-1:0] cur_word = '0;
   bit               track = 1'b0;

   task automatic check_eq(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   function automatic void refresh();
      tx_empty = (tx_q.size() == 0);
      tx_dout  = tx_empty ? '0 : tx_q[0];
   endfunction

   // Reference: the serial order in which the word's bits must appear on the wire
   function automatic int exp_bit(input logic [WIDTH-1:0] w, input int idx);
`ifdef SPI_LSB_FIRST_EN
      return int'(w[idx]);
`else
      return int'(w[WIDTH-1-idx]);
`endif
   endfunction

   task automatic push_word(input logic [WIDTH-1:0] w, input bit expect_rx);
      tx_q.push_back(w);
      if (expect_rx) exp_q.push_back(w);
      refresh();
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      repeat (3) @(negedge clk);
      while (busy && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check_eq({"idle_timeout_", name}, int'(busy), 0);
   endtask

   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         track    = 1'b0;
         prev_sck = 1'b0;
      end else begin
         if (busy) busy_cyc++;
         if (sck && !prev_sck && track) begin
            if (rises < WIDTH) check_eq("mosi_bit", int'(mosi), exp_bit(cur_word, rises));
            rises++;
         end
         prev_sck = sck;
         if (tx_rd) begin
            check_eq("rd_wr_excl", int'(rx_wr), 0);
            check_eq("sck_in_load", int'(sck), 0);
            check_eq("ss_n_in_load", int'(ss_n), 0);
            rd_cnt++;
            cur_word = tx_dout;
            track    = 1'b1;
            rises    = 0;
            load_cyc = cyc;
            if (tx_q.size() > 0) void'(tx_q.pop_front());
            else check_eq("pop_from_empty", 1, 0);
            refresh();
         end
         if (rx_wr) begin
            rx_cnt++;
            check_eq("sck_in_store", int'(sck), 0);
            check_eq("shift_len", cyc - load_cyc, SHIFT_CYC + 1);
            check_eq("sck_rises", rises, WIDTH);
            if (exp_q.size() == 0) check_eq("unexpected_rx_wr", int'(rx_din), -1);
            else check_eq("rx_din", int'(rx_din), int'(exp_q.pop_front()));
            track = 1'b0;
         end
         if (!busy) begin
            check_eq("idle_ss_n", int'(ss_n), 1);
            check_eq("idle_sck", int'(sck), 0);
            check_eq("idle_mosi", int'(mosi), 0);
         end else begin
            check_eq("busy_ss_n", int'(ss_n), 0);
         end
      end
   end

   initial begin
      int total;
      int r;
      int n;
      logic p;
      rst_n      = 1'b0;
      en         = 1'b1;
      rx_full    = 1'b0;
      loop       = 1'b1;
      miso_force = 1'b0;
      refresh();
      push_word(8'hA5, 1'b1);

      repeat (2) @(negedge clk);
      check_eq("rst_sck", int'(sck), 0);
      check_eq("rst_mosi", int'(mosi), 0);
      check_eq("rst_ss_n", int'(ss_n), 1);
      check_eq("rst_tx_rd", int'(tx_rd), 0);
      check_eq("rst_rx_wr", int'(rx_wr), 0);
      check_eq("rst_busy", int'(busy), 0);
      check_eq("rst_rx_din", int'(rx_din), 0);

      // Single word with loopback; start must wait for the second edge after reset
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("no_load_first_edge", int'(busy), 0);
      @(negedge clk);
      check_eq("load_second_edge", int'(tx_rd), 1);
      wait_idle("a5");
      check_eq("a5_rd_cnt", rd_cnt, 1);
      check_eq("a5_rx_cnt", rx_cnt, 1);
      check_eq("a5_ss_n", int'(ss_n), 1);

      // Three back-to-back words: busy must stay high for exactly three word slots
      busy_cyc = 0;
      push_word(8'h3C, 1'b1);
      push_word(8'hF0, 1'b1);
      push_word(8'h01, 1'b1);
      wait_idle("b2b");
      check_eq("b2b_busy_cycles", busy_cyc, 3 * (SHIFT_CYC + 2));
      check_eq("b2b_rx_cnt", rx_cnt, 4);

      // RX full blocks the start; release starts on the next edge
      rx_full = 1'b1;
      push_word(8'h5A, 1'b1);
      repeat (10) @(negedge clk);
      check_eq("rxfull_busy", int'(busy), 0);
      check_eq("rxfull_rd_cnt", rd_cnt, 4);
      rx_full = 1'b0;
      @(negedge clk);
      check_eq("rxfull_release_load", int'(tx_rd), 1);
      wait_idle("rxfull");

      // en dropped mid-SHIFT: first word finishes, second never starts
      push_word(8'hC3, 1'b1);
      push_word(8'h69, 1'b0);
      repeat (12) @(negedge clk);
      en = 1'b0;
      wait_idle("en_drop");
      check_eq("en_drop_rx_cnt", rx_cnt, 6);
      repeat (10) @(negedge clk);
      check_eq("en_drop_stays_idle", int'(busy), 0);
      check_eq("en_drop_left_in_fifo", tx_q.size(), 1);
      tx_q.delete();
      refresh();

      // Reset after the third sck rise with miso held high
      loop       = 1'b0;
      miso_force = 1'b1;
      en         = 1'b1;
      push_word(8'h77, 1'b0);
      r = 0;
      n = 0;
      p = 1'b0;
      while (r < 3 && n < 500) begin
         @(negedge clk);
         if (sck && !p) r++;
         p = sck;
         n++;
      end
      check_eq("third_rise_seen", r, 3);
      rst_n = 1'b0;
      en    = 1'b0;
      #1;
      check_eq("midrst_ss_n", int'(ss_n), 1);
      check_eq("midrst_sck", int'(sck), 0);
      check_eq("midrst_busy", int'(busy), 0);
      check_eq("midrst_rx_wr", int'(rx_wr), 0);
      check_eq("midrst_rx_din", int'(rx_din), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      check_eq("midrst_no_rx_wr", rx_cnt, 6);

      // Randomized batches in loopback
      loop  = 1'b1;
      en    = 1'b1;
      total = 0;
      for (int i = 0; i < 15; i++) begin
         int k;
         k = $urandom_range(1, 3);
         for (int j = 0; j < k; j++) push_word(WIDTH'($urandom), 1'b1);
         total += k;
         wait_idle("random");
         repeat ($urandom_range(0, 4)) @(negedge clk);
      end
      check_eq("random_rx_cnt", rx_cnt, 6 + total);
      check_eq("exp_q_drained", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/spi_xfer_ctrl.md
SPI_XFER_CTRL -- requirements
Module: spi_xfer_ctrl

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8: transfer word width in bits and FIFO data width.
REQ-002 The module SHALL have parameter DIV, default 2: SCK half-period in clk cycles, legal range 1..255.
REQ-003 The module SHALL have port clk  input  1  sole clock, rising-edge active.
REQ-004 The module SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 The module SHALL have port en  input  1  transfer enable, level-sensitive.
REQ-006 The module SHALL have ports tx_empty  input  1, tx_dout  input  WIDTH, and tx_rd  output  1: TX FIFO status, combinational head data, and pop strobe.
REQ-007 The module SHALL have ports rx_full  input  1, rx_din  output  WIDTH, and rx_wr  output  1: RX FIFO status, push data, and push strobe.
REQ-008 The module SHALL have ports sck  output  1, mosi  output  1, miso  input  1, and ss_n  output  1: SPI mode 0 pins.
REQ-009 The module SHALL have port busy  output  1: high whenever the state is not IDLE.

Function
REQ-010 The FSM SHALL have exactly the states IDLE, LOAD, SHIFT and STORE.
REQ-011 The FSM SHALL go IDLE->LOAD when en=1, tx_empty=0 and rx_full=0 in the same cycle; otherwise it SHALL hold IDLE.
REQ-012 In LOAD, tx_rd SHALL be 1 for exactly one cycle, the TX shift register SHALL capture tx_dout, ss_n SHALL be driven 0, and the FSM SHALL go to SHIFT.
REQ-013 In SHIFT, a divider SHALL toggle sck every DIV clk cycles, giving 2*WIDTH toggles and SHIFT lasting exactly 2*WIDTH*DIV cycles.
REQ-014 mosi SHALL present the current TX bit from LOAD onward; on each sck rising edge the RX shift register SHALL sample miso, and on each sck falling edge mosi SHALL advance to the next bit.
REQ-015 Bit order SHALL be MSB first unless the Configuration macro is defined.
REQ-016 After the final falling edge (sck=0), the FSM SHALL enter STORE, where rx_wr=1 for exactly one cycle and rx_din equals the received word.
REQ-017 From STORE the FSM SHALL go to LOAD if the IDLE->LOAD condition holds, keeping ss_n=0 (back-to-back); otherwise it SHALL go to IDLE and set ss_n=1.
REQ-018 Deasserting en during LOAD or SHIFT SHALL NOT abort: the current word SHALL complete through STORE.
REQ-019 tx_rd and rx_wr SHALL never be 1 in the same cycle, and SHALL never be 1 outside LOAD and STORE respectively.
REQ-020 sck SHALL be 0 in IDLE, LOAD and STORE.
REQ-021 The miso input SHALL be sampled only on internal sck rising events; no other miso path SHALL exist.
REQ-022 The divider counter SHALL be ceil(log2(DIV+1)) bits wide, and the bit counter SHALL be ceil(log2(WIDTH+1)) bits wide; neither SHALL wrap during a word.

Reset
REQ-023 rst_n=0 SHALL asynchronously force state=IDLE, sck=0, mosi=0, ss_n=1, tx_rd=0, rx_wr=0, busy=0, rx_din=0, and clear both counters and both shift registers.
REQ-024 Reset asserted mid-transfer SHALL discard the partial word, generate no rx_wr, and raise ss_n immediately.
REQ-025 After rst_n deasserts, the first LOAD SHALL occur no earlier than the second rising clk edge.

Configuration
REQ-026 When macro SPI_LSB_FIRST_EN is defined, TX SHALL shift out bit 0 first and RX SHALL shift in from the MSB side, so rx_din bit 0 is the first bit received.
REQ-027 When SPI_LSB_FIRST_EN is not defined, TX and RX SHALL be MSB first.
REQ-028 Defining or omitting SPI_LSB_FIRST_EN SHALL NOT change the port list or any timing.

Verification
REQ-029 With DIV=2, WIDTH=8, miso tied to mosi, TX FIFO holding 0xA5 and en=1, the bench SHALL check: one tx_rd pulse, SHIFT lasting 32 cycles, then rx_wr with rx_din=0xA5 and ss_n returning to 1.
REQ-030 With TX FIFO holding 0x3C, 0xF0, 0x01 and en held at 1, the bench SHALL check three back-to-back words, ss_n low continuously from the first LOAD to the last STORE, and RX receiving 0x3C, 0xF0, 0x01.
REQ-031 With rx_full=1, tx_empty=0 and en=1, the bench SHALL check that the FSM stays IDLE with no tx_rd; after rx_full falls, LOAD SHALL occur on the next cycle.
REQ-032 With miso=1 and rst_n pulsed low after the 3rd sck rise, the bench SHALL check that ss_n=1 and sck=0 follow immediately, that no rx_wr is generated, and that busy=0.
REQ-033 With en dropped to 0 mid-SHIFT, the bench SHALL check that the word completes with rx_wr pulsing once and the FSM then returns to IDLE.
REQ-034 With SPI_LSB_FIRST_EN defined and TX 0x01, the bench SHALL check that mosi is 1 during the first bit period and 0 thereafter, and that loopback yields rx_din=0x01.
